// File: rtl/cdb_pkg.sv
// Shared widths and the CDB broadcast packet seen by the ROB and reservation stations.
package cdb_pkg;

  localparam int CDB_FU_NUM = 4;
  localparam int CDB_XLEN   = 32;
  localparam int CDB_TAG_W  = 6;
  localparam int CDB_ID_W   = $clog2(CDB_FU_NUM);

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  rob_tag;
    logic [CDB_XLEN-1:0]   value;
    logic [CDB_ID_W-1:0]   fu_id;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
// Zero latency; no state, the pointer lives in the caller.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// One-entry holding register per FU, round-robin granted onto a registered CDB.
// Transfer to broadcast >= 1 cycle; an FU stalls only while its own entry is held and not granted.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter  int FU_NUM = CDB_FU_NUM,
  parameter  int XLEN   = CDB_XLEN,
  parameter  int TAG_W  = CDB_TAG_W,
  localparam int IDW    = $clog2(FU_NUM)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [FU_NUM-1:0]       fu_valid,
  output logic [FU_NUM-1:0]       fu_ready,
  input  logic [FU_NUM*TAG_W-1:0] fu_rob_tag,
  input  logic [FU_NUM*XLEN-1:0]  fu_value,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_rob_tag,
  output logic [XLEN-1:0]         cdb_value,
  output logic [IDW-1:0]          cdb_fu_id
);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  rob_tag;
    logic [XLEN-1:0]   value;
    logic [IDW-1:0]    fu_id;
  } pkt_t;

  logic [FU_NUM-1:0] hold_valid;
  logic [TAG_W-1:0]  hold_tag   [FU_NUM];
  logic [XLEN-1:0]   hold_value [FU_NUM];
  logic [IDW-1:0]    rr_ptr;
  logic [FU_NUM-1:0] grant;
  logic [IDW-1:0]    grant_idx;
  logic              any_grant;
  logic [FU_NUM-1:0] accept;
  pkt_t              cdb_q;

  rr_arbiter #(.N(FU_NUM)) u_rr (
    .req       (hold_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Ready comes from registered state only, so it never loops back through fu_valid.
  assign fu_ready = ~hold_valid | grant;
  assign accept   = fu_valid & fu_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid <= '0;
      for (int i = 0; i < FU_NUM; i++) begin
        hold_tag[i]   <= '0;
        hold_value[i] <= '0;
      end
    end else if (flush) begin
      hold_valid <= '0;
    end else begin
      for (int i = 0; i < FU_NUM; i++) begin
        if (accept[i]) begin
          hold_valid[i] <= 1'b1;
          hold_tag[i]   <= fu_rob_tag[i*TAG_W +: TAG_W];
          hold_value[i] <= fu_value[i*XLEN +: XLEN];
        end else if (grant[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Flush squashes the outgoing broadcast but leaves the pointer and last data alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      cdb_q  <= '0;
    end else if (flush) begin
      cdb_q.valid <= 1'b0;
    end else if (any_grant) begin
      rr_ptr        <= (grant_idx == IDW'(FU_NUM - 1)) ? '0 : grant_idx + IDW'(1);
      cdb_q.valid   <= 1'b1;
      cdb_q.rob_tag <= hold_tag[grant_idx];
      cdb_q.value   <= hold_value[grant_idx];
      cdb_q.fu_id   <= grant_idx;
    end else begin
      cdb_q.valid <= 1'b0;
    end
  end

  assign cdb_valid   = cdb_q.valid;
  assign cdb_rob_tag = cdb_q.rob_tag;
  assign cdb_value   = cdb_q.value;
  assign cdb_fu_id   = cdb_q.fu_id;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed stimulus against a queue-style reference model of the CDB arbiter.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N = CDB_FU_NUM;
  localparam int TW = CDB_TAG_W;
  localparam int XW = CDB_XLEN;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                flush = 1'b0;
  logic [N-1:0]        fu_valid = '0;
  logic [N-1:0]        fu_ready;
  logic [N*TW-1:0]     fu_rob_tag = '0;
  logic [N*XW-1:0]     fu_value = '0;
  logic                cdb_valid;
  logic [TW-1:0]       cdb_rob_tag;
  logic [XW-1:0]       cdb_value;
  logic [CDB_ID_W-1:0] cdb_fu_id;

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_rob_tag(fu_rob_tag), .fu_value(fu_value),
    .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag),
    .cdb_value(cdb_value), .cdb_fu_id(cdb_fu_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // FU-side offers
  logic          off_v   [N];
  logic [TW-1:0] off_tag [N];
  logic [XW-1:0] off_val [N];

  // Reference model
  logic          m_held [N];
  logic [TW-1:0] m_tag  [N];
  logic [XW-1:0] m_val  [N];
  int            m_ptr;
  cdb_packet_t   m_cdb;
  int            cyc = 0;
  int            acc_cyc [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_held[i] = 1'b0; m_tag[i] = '0; m_val[i] = '0; off_v[i] = 1'b0;
      off_tag[i] = '0; off_val[i] = '0; acc_cyc[i] = 0;
    end
    m_ptr = 0;
    m_cdb = '0;
  endtask

  // Winner = held entry closest to the pointer going upward (modular distance).
  function automatic int pick();
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++)
      if (m_held[i] && ((i - m_ptr + N) % N) < bd) begin
        best = i;
        bd = (i - m_ptr + N) % N;
      end
    return best;
  endfunction

  task automatic new_offer(input int i);
    off_v[i] = 1'b1;
    off_tag[i] = TW'($urandom_range(0, (1 << TW) - 1));
    off_val[i] = $urandom;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fu_valid[i] = off_v[i];
      fu_rob_tag[i*TW +: TW] = off_tag[i];
      fu_value[i*XW +: XW] = off_val[i];
    end
  endtask

  // One clock: check ready, step the model across the edge, check the broadcast.
  task automatic tick();
    int win;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] newly;
    drive();
    win = pick();
    for (int i = 0; i < N; i++) exp_rdy[i] = !m_held[i] || (win == i);
    #1;
    chk("fu_ready", fu_ready, exp_rdy);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    newly = '0;
    if (flush) begin
      for (int i = 0; i < N; i++) m_held[i] = 1'b0;
      m_cdb.valid = 1'b0;
    end else if (win >= 0) begin
      m_cdb.valid = 1'b1;
      m_cdb.rob_tag = m_tag[win];
      m_cdb.value = m_val[win];
      m_cdb.fu_id = CDB_ID_W'(win);
      m_held[win] = 1'b0;
      m_ptr = (win + 1) % N;
    end else begin
      m_cdb.valid = 1'b0;
    end
    for (int i = 0; i < N; i++)
      if (off_v[i] && exp_rdy[i]) begin
        if (!flush) begin
          m_held[i] = 1'b1; m_tag[i] = off_tag[i]; m_val[i] = off_val[i];
          newly[i] = 1'b1;
        end
        off_v[i] = 1'b0;
      end
    chk("cdb_valid", cdb_valid, m_cdb.valid);
    chk("cdb_rob_tag", cdb_rob_tag, m_cdb.rob_tag);
    chk("cdb_value", cdb_value, m_cdb.value);
    chk("cdb_fu_id", cdb_fu_id, m_cdb.fu_id);
    if (cdb_valid && m_cdb.valid)
      chk("wait_bound", (cyc - acc_cyc[cdb_fu_id]) <= N, 1'b1);
    for (int i = 0; i < N; i++) if (newly[i]) acc_cyc[i] = cyc;
  endtask

  initial begin
    model_reset();
    // 1: reset with random inputs
    #1 reset = 1'b0;
    for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) new_offer(i);
    flush = 1'($urandom_range(0, 1));
    drive();
    #2;
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_fu_ready", fu_ready, {N{1'b1}});
    chk("rst_tag", cdb_rob_tag, '0);
    chk("rst_value", cdb_value, '0);
    chk("rst_id", cdb_fu_id, '0);
    @(negedge clk);
    model_reset();
    flush = 1'b0;
    reset = 1'b1;
    repeat (2) tick();

    // 2: single transfer from FU2
    off_v[2] = 1'b1; off_tag[2] = TW'(5); off_val[2] = 32'hDEAD;
    tick();
    chk("single_not_yet", cdb_valid, 1'b0);
    tick();
    chk("single_valid", cdb_valid, 1'b1);
    chk("single_tag", cdb_rob_tag, 5);
    chk("single_value", cdb_value, 32'hDEAD);
    chk("single_id", cdb_fu_id, 2);
    tick();

    // 3: four-way contention from a fresh pointer
    @(negedge clk); reset = 1'b0; #1; reset = 1'b1; model_reset();
    for (int i = 0; i < N; i++) begin
      off_v[i] = 1'b1; off_tag[i] = TW'(i + 1); off_val[i] = 32'h100 + i;
    end
    tick();
    for (int k = 0; k < N; k++) begin
      tick();
      chk("cont_id", cdb_fu_id, k);
      chk("cont_tag", cdb_rob_tag, k + 1);
    end
    tick();

    // 6: async reset in the middle of a contention burst
    for (int i = 0; i < N; i++) begin
      off_v[i] = 1'b1; off_tag[i] = TW'(i + 9); off_val[i] = $urandom;
    end
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_cdb_valid", cdb_valid, 1'b0);
    chk("arst_fu_ready", fu_ready, {N{1'b1}});
    model_reset();
    drive();
    @(negedge clk); reset = 1'b1;
    repeat (3) tick();

    // 4: FU1 streams while FU3 stays busy
    for (int c = 0; c < 12; c++) begin
      if (!off_v[1]) new_offer(1);
      if (!off_v[3]) new_offer(3);
      tick();
    end
    repeat (3) tick();

    // 5: flush with three entries held and a transfer in the same cycle
    for (int i = 0; i < 3; i++) new_offer(i);
    tick();
    new_offer(3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_cdb_valid", cdb_valid, 1'b0);
    chk("flush_ready", fu_ready, {N{1'b1}});
    repeat (4) tick();

    // Random traffic with occasional flushes
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!off_v[i] && $urandom_range(0, 2) == 0) new_offer(i);
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
